instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the opcode decoder. Accepts decoded control bundles and encodes each to its 4-bit opcode.
//  Bundles arrive as alufunc plus branch/flush/RegWrite/MemWrite/MemToReg/immediate.
//  Packs the opcode with register/immediate fields into an instruction word.
//  Streams words into instruction memory through a stallable write port.
//  Sits between the test/boot program source and instruction memory, ahead of the fetch stage.
// PARAMETERS
//  ADDR_W   8   instruction-memory address width; addresses wrap modulo 2^ADDR_W
//  REG_W    2   register-index width (rd, rs)
//  IMM_W    8   immediate / rt field width
//  (derived) INSTR_W = 4 + 2*REG_W + IMM_W = 16 by default
// PORTS
//  i_clk          in   1        clock, rising edge
//  i_rst_n        in   1        asynchronous active-low reset
//  i_start        in   1        begin a load session at i_base_addr (honoured in IDLE only)
//  i_base_addr    in   ADDR_W   first write address of the session
//  i_valid        in   1        bundle valid
//  o_ready        out  1        bundle accepted when i_valid && o_ready
//  i_last         in   1        with bundle: final bundle of session
//  i_alufunc      in   2        ALU function code
//  i_branch, i_flush, i_regwrite, i_memwrite, i_memtoreg, i_immediate   in 1 each   control flags
//  i_rd, i_rs     in   REG_W    register fields
//  i_imm          in   IMM_W    immediate or rt index (zero-extended rt when immediate=0)
//  o_mem_we       out  1        write request, held until i_mem_ready
//  i_mem_ready    in   1        memory accepts write this cycle when o_mem_we=1
//  o_mem_addr     out  ADDR_W   write address
//  o_mem_wdata    out  INSTR_W  {opcode[3:0], rd, rs, imm}
//  o_illegal      out  1        1-cycle pulse: accepted bundle matched no opcode
//  o_err_cnt      out  8        saturating count of illegal bundles since reset
//  o_wrapped      out  1        sticky per session: address counter wrapped past 2^ADDR_W-1
//  o_busy         out  1        state != IDLE
//  o_done         out  1        1-cycle pulse in DONE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; address counter and pending-write register cleared.
//  Encode table {alufunc,br,fl,rw,mw,m2r,imm} -> opcode; every other combination is illegal:
//   00,0,0,1,0,1,1->0000 LDA   00,0,0,0,1,0,1->0001 STA   00,0,0,1,0,0,0->0010 ADD
//   01,0,0,1,0,0,0->0011 SUB   10,0,0,1,0,0,0->0100 MUL   11,0,0,1,0,0,0->0101 SLT
//   00,0,0,1,0,0,1->0110 ADDI  01,0,0,1,0,0,1->0111 SUBI  10,0,0,1,0,0,1->1000 MULI
//   01,1,1,0,0,0,1->1001 BAFI  01,1,1,0,0,0,0->1010 BAFR
//  FSM IDLE -> LOAD -> DRAIN -> DONE -> IDLE.
//  IDLE:
//   - o_ready=0.
//   - i_start: load addr counter <= i_base_addr, clear o_wrapped, go LOAD.
//  LOAD:
//   - o_ready = !o_mem_we || i_mem_ready (one pending-write register).
//   - Legal accept: next cycle o_mem_we=1, addr=counter, wdata=packed word; counter +1 on accept.
//   - Illegal accept: no write, counter unchanged; o_illegal pulses next cycle; o_err_cnt +1, saturates at 255.
//   - Accept with i_last -> DRAIN (legal or illegal).
//   - i_start is ignored.
//  DRAIN:
//   - o_ready=0.
//   - Wait until no write is pending (o_mem_we=0, or handshake this cycle), then DONE.
//  DONE: o_done=1 for one cycle, then IDLE.
//  Write port and wrap:
//   - o_mem_we/addr/wdata are stable while o_mem_we=1 && !i_mem_ready.
//   - Counter wraps 2^ADDR_W-1 -> 0; o_wrapped is set on that increment.
//  Latency: accept to o_mem_we = 1 cycle; throughput 1 word/cycle when i_mem_ready=1.
//  Async reset mid-session aborts immediately; a pending write is discarded.
// TESTING
//  T1 start base=0x10, bundles ADD(rd1,rs2,rt3), LDA(imm 0x55) last, mem_ready=1 -> writes 0x10:0x2603, 0x11:0x0055; o_done 1 cycle after drain.
//  T2 all 11 legal bundles back-to-back -> opcodes 0x0..0xA in order at consecutive addresses; no o_illegal.
//  T3 bundle alufunc=11,imm=1,rw=1 -> o_illegal pulse, no write, o_err_cnt=1, next legal word at same address.
//  T4 i_mem_ready low 3 cycles mid-stream -> o_ready=0, write fields held stable, no word lost or duplicated.
//  T5 base=0xFE, 3 legal bundles -> addrs 0xFE, 0xFF, 0x00; o_wrapped=1.
//  T6 i_rst_n low during pending write -> o_mem_we=0, state IDLE, o_err_cnt=0 immediately.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: control-bundle source handshake plus instruction-memory write port.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8,
    parameter int REG_W  = 2,
    parameter int IMM_W  = 8
);
    localparam int INSTR_W = 4 + 2 * REG_W + IMM_W;
    logic               start;
    logic [ADDR_W-1:0]  base_addr;
    logic               valid;
    logic               ready;
    logic               last;
    logic [1:0]         alufunc;
    logic               branch;
    logic               flush;
    logic               regwrite;
    logic               memwrite;
    logic               memtoreg;
    logic               immediate;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs;
    logic [IMM_W-1:0]   imm;
    logic               mem_we;
    logic               mem_ready;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;
    logic               illegal;
    logic [7:0]         err_cnt;
    logic               wrapped;
    logic               busy;
    logic               done;
    modport master (
        output start, base_addr, valid, last, alufunc, branch, flush, regwrite,
               memwrite, memtoreg, immediate, rd, rs, imm, mem_ready,
        input  ready, mem_we, mem_addr, mem_wdata, illegal, err_cnt, wrapped, busy, done
    );
    modport slave (
        input  start, base_addr, valid, last, alufunc, branch, flush, regwrite,
               memwrite, memtoreg, immediate, rd, rs, imm, mem_ready,
        output ready, mem_we, mem_addr, mem_wdata, illegal, err_cnt, wrapped, busy, done
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes control bundles to opcodes and streams packed words into instruction memory.
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int REG_W  = 2,
    parameter int IMM_W  = 8
) (
    input logic clk,
    input logic rst_n,
    instr_encoder_loader_if.slave bus
);
    localparam int INSTR_W = 4 + 2 * REG_W + IMM_W;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    state_t             state, state_nx;
    logic [ADDR_W-1:0]  cnt, addr;
    logic [INSTR_W-1:0] wdata;
    logic               we, illegal, wrapped, legal, ready, accept;
    logic [7:0]         err_cnt, ctrl;
    logic [3:0]         op;
    assign ctrl = {bus.alufunc, bus.branch, bus.flush, bus.regwrite, bus.memwrite, bus.memtoreg, bus.immediate};
    always_comb begin
        legal = 1'b1;
        op = 4'h0;
        case (ctrl)
            8'h0B: op = 4'h0;
            8'h05: op = 4'h1;
            8'h08: op = 4'h2;
            8'h48: op = 4'h3;
            8'h88: op = 4'h4;
            8'hC8: op = 4'h5;
            8'h09: op = 4'h6;
            8'h49: op = 4'h7;
            8'h89: op = 4'h8;
            8'h71: op = 4'h9;
            8'h70: op = 4'hA;
            default: legal = 1'b0;
        endcase
    end
    // single pending-write register: accept only when it is free or draining this cycle
    assign ready  = (state == LOAD) && (!we || bus.mem_ready);
    assign accept = bus.valid && ready;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? LOAD : IDLE;
            LOAD:    state_nx = (accept && bus.last) ? DRAIN : LOAD;
            DRAIN:   state_nx = (!we || bus.mem_ready) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            addr    <= '0;
            wdata   <= '0;
            we      <= 1'b0;
            illegal <= 1'b0;
            wrapped <= 1'b0;
            err_cnt <= '0;
        end else begin
            illegal <= accept && !legal;
            if (state == IDLE && bus.start) begin
                cnt     <= bus.base_addr;
                wrapped <= 1'b0;
            end else if (accept && legal) begin
                cnt <= cnt + 1'b1;
                if (&cnt) wrapped <= 1'b1;
            end
            if (accept && legal) begin
                we    <= 1'b1;
                addr  <= cnt;
                wdata <= {op, bus.rd, bus.rs, bus.imm};
            end else if (bus.mem_ready) begin
                we <= 1'b0;
            end
            if (accept && !legal && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        end
    end
    assign bus.ready     = ready;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.illegal   = illegal;
    assign bus.err_cnt   = err_cnt;
    assign bus.wrapped   = wrapped;
    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed + randomized sessions scored against a queue-based reference model.
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    instr_encoder_loader_if bus ();
    instr_encoder_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic [7:0]  a;
        logic [15:0] w;
    } wr_t;
    wr_t        q[$];
    logic [7:0] tab[11] = '{8'h0B, 8'h05, 8'h08, 8'h48, 8'h88, 8'hC8, 8'h09, 8'h49, 8'h89, 8'h71, 8'h70};
    int         phase = 0;
    logic [7:0] ctr = 0;
    bit         wrap_m = 0, ill_m = 0;
    int         err_m = 0;
    int         stall_pct = 0, stall_left = 0;
    int         n_vec = 0, n_err = 0;

    function automatic int enc(input logic [7:0] c);
        for (int i = 0; i < 11; i++) if (tab[i] == c) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit v, input bit lst, input logic [7:0] c, input logic [1:0] d, input logic [1:0] s,
                        input logic [7:0] im, input bit st, input logic [7:0] ba, output bit acc);
        bit mr, exp_rdy, wr, drained;
        int op;
        @(negedge clk);
        mr = (stall_left > 0) ? 1'b0 : ($urandom_range(99) >= stall_pct);
        if (stall_left > 0) stall_left--;
        bus.valid = v; bus.last = lst; bus.rd = d; bus.rs = s; bus.imm = im;
        {bus.alufunc, bus.branch, bus.flush, bus.regwrite, bus.memwrite, bus.memtoreg, bus.immediate} = c;
        bus.start = st; bus.base_addr = ba; bus.mem_ready = mr;
        #1;
        exp_rdy = (phase == 1) && (q.size() == 0 || mr);
        chk("ready", bus.ready, exp_rdy);
        chk("mem_we", bus.mem_we, q.size() != 0);
        if (q.size() != 0) begin
            chk("mem_addr", bus.mem_addr, q[0].a);
            chk("mem_wdata", bus.mem_wdata, q[0].w);
        end
        chk("illegal", bus.illegal, ill_m);
        chk("err_cnt", bus.err_cnt, err_m);
        chk("wrapped", bus.wrapped, wrap_m);
        chk("busy", bus.busy, phase != 0);
        chk("done", bus.done, phase == 3);
        acc = v && exp_rdy;
        wr = (q.size() != 0) && mr;
        drained = (q.size() == 0) || mr;
        @(posedge clk);
        if (wr) void'(q.pop_front());
        ill_m = 0;
        case (phase)
            0: if (st) begin ctr = ba; wrap_m = 0; phase = 1; end
            1: if (acc) begin
                op = enc(c);
                if (op < 0) begin
                    ill_m = 1;
                    if (err_m < 255) err_m++;
                end else begin
                    q.push_back('{ctr, {op[3:0], d, s, im}});
                    if (ctr == 8'hFF) wrap_m = 1;
                    ctr = ctr + 8'd1;
                end
                if (lst) phase = 2;
            end
            2: if (drained) phase = 3;
            default: phase = 0;
        endcase
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 2'd0, 2'd0, 8'h00, 0, 8'h00, a);
    endtask

    task automatic begin_session(input logic [7:0] ba);
        bit a;
        tick(0, 0, 8'h00, 2'd0, 2'd0, 8'h00, 1, ba, a);
    endtask

    task automatic send(input logic [7:0] c, input logic [1:0] d, input logic [1:0] s, input logic [7:0] im, input bit lst);
        bit a = 0;
        for (int i = 0; i < 50 && !a; i++) tick(1, lst, c, d, s, im, $urandom_range(1), 8'($urandom), a);
        if (!a) chk("send_timeout", 0, 1);
    endtask

    task automatic end_session();
        for (int i = 0; i < 30 && phase != 0; i++) idle(1);
        if (phase != 0) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        bit a;
        int n;
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        bus.start = 0; bus.base_addr = 0; bus.valid = 0; bus.last = 0; bus.alufunc = 0;
        bus.branch = 0; bus.flush = 0; bus.regwrite = 0; bus.memwrite = 0; bus.memtoreg = 0;
        bus.immediate = 0; bus.rd = 0; bus.rs = 0; bus.imm = 0; bus.mem_ready = 0;
        #12;
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        chk("rst_addr", bus.mem_addr, 0);
        @(negedge clk) rst_n = 1;
        // T1: two-word session
        begin_session(8'h10);
        send(8'h08, 2'd1, 2'd2, 8'h03, 0);
        send(8'h0B, 2'd0, 2'd0, 8'h55, 1);
        end_session();
        // T2: every legal bundle back-to-back
        begin_session(8'h20);
        for (int i = 0; i < 11; i++) send(tab[i], 2'($urandom), 2'($urandom), 8'($urandom), i == 10);
        end_session();
        // T3: illegal bundle between legal ones
        begin_session(8'h40);
        send(8'h09, 2'd1, 2'd1, 8'h11, 0);
        send(8'hC9, 2'd2, 2'd3, 8'h22, 0);
        send(8'h48, 2'd3, 2'd0, 8'h33, 1);
        end_session();
        // T4: memory stalls mid-stream
        begin_session(8'h60);
        send(8'h88, 2'd1, 2'd2, 8'h01, 0);
        send(8'hC8, 2'd2, 2'd1, 8'h02, 0);
        stall_left = 3;
        send(8'h49, 2'd3, 2'd3, 8'h03, 0);
        send(8'h71, 2'd0, 2'd1, 8'h04, 0);
        send(8'h05, 2'd1, 2'd0, 8'h05, 1);
        end_session();
        // T5: address wrap
        begin_session(8'hFE);
        for (int i = 0; i < 3; i++) send(tab[$urandom_range(10)], 2'($urandom), 2'($urandom), 8'($urandom), i == 2);
        end_session();
        idle(2);
        // randomized sessions with stalls, gaps and stray illegal bundles
        stall_pct = 30;
        for (int s = 0; s < 6; s++) begin
            begin_session(8'($urandom));
            n = $urandom_range(3, 12);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(3) == 0) idle(1);
                send(($urandom_range(3) == 0) ? 8'($urandom) : tab[$urandom_range(10)],
                     2'($urandom), 2'($urandom), 8'($urandom), k == n - 1);
            end
            end_session();
        end
        // error counter saturation
        stall_pct = 0;
        begin_session(8'h00);
        for (int k = 0; k < 260; k++) send(8'hFF, 2'd0, 2'd0, 8'h00, k == 259);
        end_session();
        // T6: async reset during a stalled pending write
        begin_session(8'h80);
        stall_left = 10;
        send(8'h08, 2'd1, 2'd1, 8'h01, 0);
        idle(1);
        #2;
        rst_n = 0;
        #1;
        chk("t6_mem_we", bus.mem_we, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_err_cnt", bus.err_cnt, 0);
        chk("t6_ready", bus.ready, 0);
        q.delete();
        phase = 0; ctr = 0; wrap_m = 0; ill_m = 0; err_m = 0; stall_left = 0;
        @(negedge clk) rst_n = 1;
        begin_session(8'h90);
        send(8'h0B, 2'd2, 2'd1, 8'hA5, 1);
        end_session();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
